mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enable strobes for the PC, IR, MDR and register file. It shares one single-port memory between instruction fetch and load/store using a req/ready handshake. It sits beside the combinational decoder `cu` and gates that decoder's `regfile` and `memwrite` outputs so they take effect only in the correct phase.

## Interface
- `TIMEOUT`, default 255: maximum number of wait cycles on the memory handshake before a timeout trap. Used only with `MC_SEQ_TIMEOUT_EN`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `run` input 1: allows new instructions to start.
- `opcode` input 7: IR[6:0] of the current instruction.
- `regfile_dec` input 1: register-write request from `cu`.
- `memwrite_dec` input 1: store request from `cu`.
- `mem_ready` input 1: memory has completed the current request.
- `mem_req` output 1: memory request; held high until `mem_ready`.
- `mem_we` output 1: memory write strobe.
- `mem_addr_sel` output 1: address select; 0 = PC, 1 = ALU result.
- `ir_en` output 1: IR load strobe.
- `mdr_en` output 1: load-data register load strobe.
- `rf_we` output 1: register-file write enable.
- `pc_en` output 1: PC update strobe.
- `state` output 3: current state, for debug.
- `busy` output 1: high in any state other than IDLE and TRAP.
- `trap` output 1: sticky fault flag.
- `trap_cause` output 2: 01 = illegal opcode, 10 = memory timeout.
- `instret` output 32: count of retired instructions.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Encoding 7 is unreachable; if entered, the next state is IDLE.
- Strobes depend on `state` plus `mem_ready`. Every strobe not listed for a state is 0.
- IDLE: go to FETCH if `run`=1, otherwise stay.
- FETCH:
  - Drives `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - When `mem_ready`=1: `ir_en`=1 in the same cycle, then go to DECODE.
- DECODE: lasts one cycle.
  - Legal opcodes: 0110011, 0010011, 0100011, 0000011, 0110111, 0010111, 1101111, 1100011, 1100111.
  - Any other opcode goes to TRAP with `trap_cause`=01. Otherwise go to EXEC.
- EXEC: lasts one cycle. Opcode 0000011 or 0100011 goes to MEM; all others go to WB.
- MEM:
  - Drives `mem_req`=1, `mem_addr_sel`=1, `mem_we`=`memwrite_dec`.
  - When `mem_ready`=1: `mdr_en`=1 if the opcode is a load, then go to WB.
- WB:
  - Drives `rf_we`=`regfile_dec` and `pc_en`=1; `instret` increments.
  - Then go to FETCH if `run`=1, otherwise IDLE.
- TRAP: `trap`=1, all strobes 0; the block stays here until reset.
- `instret` wraps from 0xFFFFFFFF to 0 with no flag.
- Register-writing stores cannot occur: for a store, `rf_we` takes `regfile_dec`, which `cu` drives to 0.

## Timing
- Reset (any state, including mid-FETCH or mid-MEM): at the next edge with `rst_n`=0:
  - `state`=IDLE.
  - `trap`=0, `trap_cause`=00, `instret`=0.
  - Every strobe, `mem_req` and `busy` read 0 from that edge onward.
- Minimum latency with `mem_ready` already high when the request is issued:
  - ALU, branch, jump, LUI or AUIPC: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
- Each wait cycle with `mem_ready`=0 adds one cycle. `mem_req` and `mem_addr_sel` stay stable while waiting.
- `mem_ready` outside FETCH and MEM is ignored.
- Deasserting `run` mid-instruction does not abort it: the instruction retires, then the block enters IDLE.
- Asserting `run` while in IDLE: FETCH begins on the following cycle.
- `pc_en` and `rf_we` are asserted for exactly one cycle per instruction.

## Configuration
- `MC_SEQ_TIMEOUT_EN` defined:
  - An 8-bit-or-wider wait counter clears on entry to FETCH or MEM and counts cycles with `mem_req`=1 and `mem_ready`=0.
  - When the counter reaches `TIMEOUT`, the next state is TRAP with `trap_cause`=10.
  - If `mem_ready` and the timeout occur in the same cycle, `mem_ready` wins.
- `MC_SEQ_TIMEOUT_EN` not defined: no counter exists, waits are unbounded, and `trap_cause`=10 is never produced.

## Test plan
- `run`=1, `mem_ready` tied 1, ADD (opcode 0110011, `regfile_dec`=1) -> states 1,2,3,5,1. `ir_en` is high in cycle 1, `rf_we` and `pc_en` are high in cycle 4, `instret`=1.
- Load (0000011) with `mem_ready` low for 3 cycles in MEM -> `mem_req`/`mem_addr_sel`=1 held for 4 cycles, `mdr_en` pulses once, the instruction retires in 8 cycles and `rf_we`=1 in WB.
- Store (0100011, `memwrite_dec`=1) -> `mem_we`=1 only in MEM, `rf_we`=0, `pc_en`=1 in WB.
- Opcode 0000000 -> TRAP after DECODE with `trap`=1, `trap_cause`=01 and no further `mem_req`. Then `rst_n`=0 for 1 cycle -> IDLE, `trap`=0.
- `rst_n`=0 asserted mid-MEM -> next edge `state`=IDLE with `mem_req`=0, `instret`=0. Deasserting `run` during EXEC -> WB, then IDLE.
- With `MC_SEQ_TIMEOUT_EN` and `TIMEOUT`=4, `mem_ready` held 0 in FETCH -> TRAP with `trap_cause`=10 after 4 wait cycles. Without the macro, the block remains in FETCH.

Source files
------------

// File: rtl/mc_seq_if.sv
// Bundle of control, handshake and status signals between the multi-cycle
// sequencer (slave) and the core datapath/decoder/memory side (master).
interface mc_seq_if;
  logic        run;
  logic [6:0]  opcode;
  logic        regfile_dec;
  logic        memwrite_dec;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_en;
  logic        mdr_en;
  logic        rf_we;
  logic        pc_en;
  logic [2:0]  state;
  logic        busy;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  modport slave (
    input  run, opcode, regfile_dec, memwrite_dec, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_en, mdr_en, rf_we, pc_en,
           state, busy, trap, trap_cause, instret
  );

  modport master (
    output run, opcode, regfile_dec, memwrite_dec, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_en, mdr_en, rf_we, pc_en,
           state, busy, trap, trap_cause, instret
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared memory port.
// Optional memory-handshake timeout trap enabled by defining MC_SEQ_TIMEOUT_EN.
module mc_sequencer #(
  parameter int TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst_n,
  mc_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100011, 7'b1100111: is_legal = 1'b1;
      default:                                        is_legal = 1'b0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q, instret_d;
  logic        timeout_hit;

`ifdef MC_SEQ_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counter is zero whenever outside FETCH/MEM, so every entry starts clean.
  always_comb begin
    wait_cnt_d  = '0;
    timeout_hit = 1'b0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) begin
      wait_cnt_d  = wait_cnt_q + 1'b1;
      timeout_hit = (32'(wait_cnt_d) == 32'(TIMEOUT));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    trap_d           = trap_q;
    cause_d          = cause_q;
    instret_d        = instret_q;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_en        = 1'b0;
    bus.mdr_en       = 1'b0;
    bus.rf_we        = 1'b0;
    bus.pc_en        = 1'b0;

    case (state_q)
      S_IDLE: if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_en = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (is_legal(bus.opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) state_d = S_MEM;
        else                                                 state_d = S_WB;
      end
      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = bus.memwrite_dec;
        if (bus.mem_ready) begin
          bus.mdr_en = (bus.opcode == OP_LOAD);
          state_d    = S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        bus.rf_we = bus.regfile_dec;
        bus.pc_en = 1'b1;
        instret_d = instret_q + 32'd1;
        state_d   = bus.run ? S_FETCH : S_IDLE;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed self-checking bench for mc_sequencer: instruction classes, memory
// wait states, run gating, illegal-opcode trap, reset and handshake timeout.
module tb_mc_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_instret = 32'd0;

  mc_seq_if bus ();

  mc_sequencer #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic run, input logic [6:0] op, input logic rf,
                        input logic mw, input logic rdy);
    bus.run          = run;
    bus.opcode       = op;
    bus.regfile_dec  = rf;
    bus.memwrite_dec = mw;
    bus.mem_ready    = rdy;
  endtask

  task automatic test_reset();
    set_in(1'b0, 7'b0110011, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (bus.state !== ST_IDLE || bus.trap !== 1'b0 || bus.trap_cause !== 2'b00 ||
        bus.instret !== 32'd0 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d trap=%b cause=%b instret=%0d req=%b busy=%b, required 0/0/00/0/0/0",
               bus.state, bus.trap, bus.trap_cause, bus.instret, bus.mem_req, bus.busy);
    end
    rst_n = 1'b1;
  endtask

  // ADD back-to-back with run dropped during the second instruction.
  task automatic test_alu_run_drop();
    logic [2:0] seq [9];
    int pc_pulses = 0;
    seq = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_IDLE};
    set_in(1'b1, 7'b0110011, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 5) bus.run = 1'b0;
      #1;
      checks++;
      if (bus.state !== seq[i]) begin
        errors++;
        $display("FAIL alu_state[%0d]: got %0d required %0d", i, bus.state, seq[i]);
      end
      checks++;
      if (bus.ir_en !== (seq[i] == ST_FETCH) || bus.rf_we !== (seq[i] == ST_WB)) begin
        errors++;
        $display("FAIL alu_strobes[%0d]: ir_en=%b rf_we=%b in state %0d", i, bus.ir_en, bus.rf_we, seq[i]);
      end
      if (bus.pc_en === 1'b1) pc_pulses++;
      if (i == 4) begin
        exp_instret = exp_instret + 1;
        checks++;
        if (bus.instret !== exp_instret) begin
          errors++;
          $display("FAIL alu_instret: got %0d required %0d", bus.instret, exp_instret);
        end
      end
    end
    exp_instret = exp_instret + 1;
    checks++;
    if (pc_pulses != 2 || bus.instret !== exp_instret || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL alu_retire: pc_en pulses=%0d instret=%0d busy=%b required 2/%0d/0",
               pc_pulses, bus.instret, exp_instret, bus.busy);
    end
  endtask

  // Load with three MEM wait cycles: FETCH, DECODE, EXEC, 4xMEM, WB = 8 cycles.
  task automatic test_load_wait();
    int mdr_pulses = 0;
    set_in(1'b1, 7'b0000011, 1'b1, 1'b0, 1'b1);
    tick(); #1;
    if (bus.mdr_en === 1'b1) mdr_pulses++;
    tick(); #1;
    tick();
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.state !== ST_EXEC || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_exec: state=%0d req=%b required 3/0", bus.state, bus.mem_req);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state !== ST_MEM || bus.mem_req !== 1'b1 || bus.mem_addr_sel !== 1'b1 ||
          bus.mdr_en !== (i == 3) || bus.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL load_mem[%0d]: state=%0d req=%b sel=%b mdr=%b we=%b", i,
                 bus.state, bus.mem_req, bus.mem_addr_sel, bus.mdr_en, bus.mem_we);
      end
      if (bus.mdr_en === 1'b1) mdr_pulses++;
    end
    tick();
    bus.run = 1'b0;
    #1;
    checks++;
    if (bus.state !== ST_WB || bus.rf_we !== 1'b1 || bus.pc_en !== 1'b1 || mdr_pulses != 1) begin
      errors++;
      $display("FAIL load_wb: state=%0d rf_we=%b pc_en=%b mdr pulses=%0d required 5/1/1/1",
               bus.state, bus.rf_we, bus.pc_en, mdr_pulses);
    end
    tick(); #1;
    exp_instret = exp_instret + 1;
    checks++;
    if (bus.state !== ST_IDLE || bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL load_retire: state=%0d instret=%0d required 0/%0d", bus.state, bus.instret, exp_instret);
    end
  endtask

  task automatic test_store();
    logic [2:0] seq [6];
    seq = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_IDLE};
    set_in(1'b1, 7'b0100011, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus.run = 1'b0;
      #1;
      checks++;
      if (bus.state !== seq[i] || bus.mem_we !== (seq[i] == ST_MEM) || bus.rf_we !== 1'b0 ||
          bus.pc_en !== (seq[i] == ST_WB) || bus.mdr_en !== 1'b0) begin
        errors++;
        $display("FAIL store[%0d]: state=%0d we=%b rf_we=%b pc_en=%b mdr=%b, required state %0d",
                 i, bus.state, bus.mem_we, bus.rf_we, bus.pc_en, bus.mdr_en, seq[i]);
      end
    end
    exp_instret = exp_instret + 1;
    checks++;
    if (bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL store_instret: got %0d required %0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_reset_mid_mem();
    set_in(1'b1, 7'b0000011, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    tick(); tick();
    #1;
    checks++;
    if (bus.state !== ST_MEM || bus.mem_req !== 1'b1 || bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL pre_reset_mem: state=%0d req=%b instret=%0d", bus.state, bus.mem_req, bus.instret);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.run = 1'b0;
    #1;
    checks++;
    if (bus.state !== ST_IDLE || bus.mem_req !== 1'b0 || bus.instret !== 32'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mem: state=%0d req=%b instret=%0d busy=%b required 0/0/0/0",
               bus.state, bus.mem_req, bus.instret, bus.busy);
    end
    exp_instret = 32'd0;
  endtask

  task automatic test_illegal();
    set_in(1'b1, 7'b0000000, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    #1;
    checks++;
    if (bus.state !== ST_TRAP || bus.trap !== 1'b1 || bus.trap_cause !== 2'b01 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_trap: state=%0d trap=%b cause=%b busy=%b required 6/1/01/0",
               bus.state, bus.trap, bus.trap_cause, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++;
      if (bus.state !== ST_TRAP || bus.mem_req !== 1'b0 || bus.pc_en !== 1'b0 || bus.ir_en !== 1'b0) begin
        errors++;
        $display("FAIL trap_hold[%0d]: state=%0d req=%b pc_en=%b ir_en=%b", i,
                 bus.state, bus.mem_req, bus.pc_en, bus.ir_en);
      end
    end
    rst_n = 1'b0;
    bus.run = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.state !== ST_IDLE || bus.trap !== 1'b0 || bus.trap_cause !== 2'b00) begin
      errors++;
      $display("FAIL trap_reset: state=%0d trap=%b cause=%b required 0/0/00",
               bus.state, bus.trap, bus.trap_cause);
    end
  endtask

  task automatic test_timeout();
    set_in(1'b1, 7'b0110011, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checks++;
      if (bus.state !== ST_FETCH || bus.mem_req !== 1'b1 || bus.mem_addr_sel !== 1'b0 || bus.ir_en !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: state=%0d req=%b sel=%b ir_en=%b", i,
                 bus.state, bus.mem_req, bus.mem_addr_sel, bus.ir_en);
      end
    end
    tick(); #1;
`ifdef MC_SEQ_TIMEOUT_EN
    checks++;
    if (bus.state !== ST_TRAP || bus.trap !== 1'b1 || bus.trap_cause !== 2'b10 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_trap: state=%0d trap=%b cause=%b req=%b required 6/1/10/0",
               bus.state, bus.trap, bus.trap_cause, bus.mem_req);
    end
`else
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
    end
    checks++;
    if (bus.state !== ST_FETCH || bus.trap !== 1'b0 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout: state=%0d trap=%b req=%b required 1/0/1",
               bus.state, bus.trap, bus.mem_req);
    end
`endif
    rst_n = 1'b0;
    bus.run = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_alu_run_drop();
    test_load_wait();
    test_store();
    test_reset_mid_mem();
    test_illegal();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
